// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one bit per clock.
// Define SUB_SIGNED_OVF_EN to add the registered signed-overflow output ovf.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SUB_SIGNED_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr;
    logic [CNT_W-1:0] cnt;
    logic             br;
    logic             d, br_next, last_bit;

    // Single full-subtractor cell working on the current LSBs and the stored borrow.
    always_comb begin
        d        = a_sr[0] ^ b_sr[0] ^ br;
        br_next  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
        last_bit = (cnt == CNT_W'(WIDTH - 1));
    end

    // NOTE: non-blocking assignments keep every register updating from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: if (start) state_next = RUN;
            RUN: begin
                busy = 1'b1;
                if (last_bit) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are loaded only on the final RUN edge, so the previous result stays visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            bout   <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr <= a;
                        b_sr <= b;
                        br   <= bin;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= {d, res_sr[WIDTH-1:1]};
                    br     <= br_next;
                    cnt    <= cnt + 1'b1;
                    if (last_bit) begin
                        diff <= {d, res_sr[WIDTH-1:1]};
                        bout <= br_next;
`ifdef SUB_SIGNED_OVF_EN
                        // br is the borrow into the MSB stage, br_next the borrow out of it.
                        ovf  <= br ^ br_next;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed cases plus random
// operands, compared against plain-arithmetic expectations computed here.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         bin;
    logic         busy, done, bout;
    logic [W-1:0] diff;
`ifdef SUB_SIGNED_OVF_EN
    logic         ovf;
`endif

    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_diff;
    logic         exp_bout;
    logic         exp_ovf;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SUB_SIGNED_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference: unsigned (W+1)-bit difference and signed range test.
    task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin);
        int          s;
        logic [W:0]  r;
        r = {1'b0, ta} - {1'b0, tb_} - (W+1)'(tbin);
        s = int'($signed(ta)) - int'($signed(tb_)) - int'(tbin);
        exp_diff = r[W-1:0];
        exp_bout = r[W];
        exp_ovf  = (s < -128) || (s > 127);
    endtask

    task automatic check_result(input string tag);
        check({tag, "_diff"}, 32'(diff), 32'(exp_diff));
        check({tag, "_bout"}, 32'(bout), 32'(exp_bout));
`ifdef SUB_SIGNED_OVF_EN
        check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
`endif
    endtask

    // Called at a negedge with the DUT in IDLE; returns at the negedge of the following IDLE cycle.
    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tbin, input bit inject);
        a = ta; b = tb_; bin = tbin; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
        for (int i = 1; i <= W + 1; i++) begin
            @(negedge clk);
            check({tag, "_busy"}, 32'(busy), 32'(i <= W));
            check({tag, "_done"}, 32'(done), 32'(i == W + 1));
            if (i <= W) check({tag, "_held"}, 32'(diff), 32'(exp_diff));
            if (inject) begin
                if (i == 3 || i == W + 1) begin
                    start = 1'b1; a = W'($urandom); b = W'($urandom);
                end
                if (i == 4) start = 1'b0;
            end
        end
        model(ta, tb_, tbin);
        check_result(tag);
        @(negedge clk);
        start = 1'b0;
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_done"}, 32'(done), 32'd0);
        check({tag, "_idle_diff"}, 32'(diff), 32'(exp_diff));
    endtask

    initial begin
        int d1, d2;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        exp_diff = '0; exp_bout = 1'b0; exp_ovf = 1'b0;
        #3;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check_result("rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op("t200_55", 8'd200, 8'd55, 1'b0, 1'b0);
        run_op("t5_10",   8'd5,   8'd10, 1'b0, 1'b0);
        run_op("t0_0_1",  8'd0,   8'd0,  1'b1, 1'b0);
        run_op("t80_01",  8'h80,  8'h01, 1'b0, 1'b0);
        run_op("t10_01",  8'h10,  8'h01, 1'b0, 1'b0);
        run_op("t7f_ff",  8'h7f,  8'hff, 1'b0, 1'b0);
        run_op("ign",     8'd9,   8'd3,  1'b0, 1'b1);
        check("ign_val", 32'(diff), 32'd6);
        repeat (4) begin
            @(negedge clk);
            check("ign_quiet_busy", 32'(busy), 32'd0);
            check("ign_quiet_done", 32'(done), 32'd0);
            check("ign_quiet_diff", 32'(diff), 32'd6);
        end

        // Asynchronous reset in the middle of an operation.
        a = 8'd100; b = 8'd1; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        exp_diff = '0; exp_bout = 1'b0; exp_ovf = 1'b0;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check_result("arst");
        @(negedge clk);
        rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            check("arst_no_done", 32'(done), 32'd0);
            check("arst_no_busy", 32'(busy), 32'd0);
        end
        run_op("t7_7", 8'd7, 8'd7, 1'b0, 1'b0);

        // start held high: back-to-back operations.
        d1 = -1; d2 = -1;
        a = 8'd1; b = 8'd2; bin = 1'b0; start = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            if (done) begin
                if (d1 < 0) begin
                    d1 = c;
                    model(8'd1, 8'd2, 1'b0);
                    check_result("b2b1");
                    a = 8'd3; b = 8'd1;
                end else if (d2 < 0) begin
                    d2 = c;
                    model(8'd3, 8'd1, 1'b0);
                    check_result("b2b2");
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check("b2b_first", 32'(d1), 32'd9);
        check("b2b_gap", 32'(d2 - d1), 32'd10);
        check("b2b_idle", 32'(busy), 32'd0);

        for (int k = 0; k < 20; k++)
            run_op("rnd", W'($urandom), W'($urandom), 1'($urandom), 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor that computes diff = a - b - bin, LSB first, one bit per clock.
- Uses a single full-subtractor cell with a registered borrow.
- It is the subtract-direction partner of the team's adder blocks, for area-constrained arithmetic paths.
- Start/busy/done handshake. Result is held stable until the next accepted start.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend; captured on an accepted start
- b  input  WIDTH  subtrahend; captured on an accepted start
- bin  input  1  borrow-in; captured on an accepted start
- busy  output  1  high while an operation is in progress (RUN state)
- done  output  1  single-cycle pulse; the result is valid from this cycle onward
- diff  output  WIDTH  registered difference
- bout  output  1  registered borrow-out (1 = unsigned a < b + bin)
- ovf  output  1  signed overflow; present only with SUB_SIGNED_OVF_EN

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, busy=0, done=0, diff=0, bout=0, ovf=0, bit counter=0, internal shift registers=0, borrow register=0.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0.
  - start=1 captures a, b and bin into the operand shift registers and the borrow register, clears the counter, and moves to RUN.
- RUN:
  - busy=1.
  - Each cycle: d = a0 ^ b0 ^ br; br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
  - d shifts into the MSB of the result shift register. The operand registers shift right by one. The counter increments.
  - When the counter reaches WIDTH-1 (the WIDTH-th bit processed), go to DONE.
  - diff and bout outputs do not change during RUN; the previous result stays visible.
- DONE (exactly one cycle):
  - done=1, busy=0.
  - diff is loaded from the completed result shift register and bout from the final borrow, on the clock edge entering DONE. Both are visible in the DONE cycle.
  - Next state is always IDLE.
- Latency:
  - start sampled at edge T → RUN for WIDTH cycles → done high in cycle T+WIDTH+1.
  - Throughput: one operation per WIDTH+2 cycles.
- start handling:
  - start while in RUN or DONE is ignored (not queued). The requester must re-assert it in IDLE.
  - start held high continuously yields back-to-back operations, each re-capturing a, b and bin in IDLE.
- a, b and bin may change freely after capture without affecting the operation in flight.
- Arithmetic is modulo 2^WIDTH. bout is the unsigned borrow, so {bout, diff} equals a - b - bin as a (WIDTH+1)-bit two's-complement value.
- Reset mid-operation aborts immediately: no done pulse, outputs return to their reset values.

Optional Feature:
- Macro: SUB_SIGNED_OVF_EN.
- Defined:
  - Adds the ovf output and one register.
  - ovf = (borrow into the MSB stage) XOR (borrow out of the MSB stage), i.e. the signed two's-complement result is not representable.
  - Loaded on entry to DONE alongside diff; reset value 0.
- Undefined:
  - The ovf port and its logic are absent.
  - All other behaviour is identical.

Test Plan (WIDTH=8):
- a=200, b=55, bin=0, start pulse at edge T → busy for cycles T+1..T+8; done=1 only in cycle T+9; diff=145, bout=0.
- a=5, b=10, bin=0 → diff=0xFB (251), bout=1. a=0, b=0, bin=1 → diff=0xFF, bout=1.
- Run a=9, b=3, bin=0. Pulse start in RUN cycle 3 and again in the DONE cycle → both ignored; exactly one done; diff=6. Result still 6 in IDLE several cycles later.
- Start a=100, b=1. Assert rst asynchronously mid-RUN (between edges, in bit 4) → busy, done, diff and bout go to 0 immediately. No done pulse follows. Next start with a=7, b=7 → diff=0, bout=0.
- Hold start high with operand pairs (1,2) then (3,1), changing a and b each IDLE → done pulses 10 cycles apart, giving diff=0xFF/bout=1, then diff=2/bout=0.
- With SUB_SIGNED_OVF_EN: a=0x80, b=0x01 → diff=0x7F, ovf=1, bout=0; a=0x10, b=0x01 → ovf=0. Without the macro: ovf port absent, and the same diff/bout results are produced.
